// File: rtl/uart_frame_tx.sv
// ============================================================================
// Module   : uart_frame_tx
// Purpose  : Frames a captured game-state payload (header, payload MSB-first,
//            optional XOR checksum when UART_FRAME_CHECKSUM_EN is defined) and
//            hands it byte-by-byte to a UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_frame_tx #(
  parameter int         NBYTES = 4,
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  send,
  input  logic [8*NBYTES-1:0]   payload,
  input  logic                  tx_done_tick,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  output logic                  busy,
  output logic                  frame_done
);

`ifdef UART_FRAME_CHECKSUM_EN
  // One extra index bit so NBYTES=15 can still address the checksum slot (16).
  localparam int c_IDX_W = 5;
  localparam int c_LAST  = NBYTES + 1;
`else
  localparam int c_IDX_W = 4;
  localparam int c_LAST  = NBYTES;
`endif
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_LAST);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_IDX_W-1:0]   r_idx;
  logic [8*NBYTES-1:0]  r_shadow;
`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0]           r_csum;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_shadow   <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
      r_csum     <= 8'h00;
`endif
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      tx_start   <= 1'b0;
      frame_done <= 1'b0;
      case (r_state)
        // A send coinciding with frame_done is dropped; the next cycle accepts.
        S_IDLE: begin
          if (send && !frame_done) begin
            r_shadow <= payload;
            r_idx    <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
            r_csum   <= 8'h00;
`endif
            busy     <= 1'b1;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          tx_start <= 1'b1;
          r_state  <= S_WAIT;
          if (r_idx == '0) begin
            tx_data <= HEADER;
`ifdef UART_FRAME_CHECKSUM_EN
          end else if (r_idx == c_LAST_IDX) begin
            tx_data <= r_csum;
`endif
          end else begin
            // Shadow shifts left so the next payload byte is always on top.
            tx_data  <= r_shadow[8*NBYTES-1 -: 8];
            r_shadow <= r_shadow << 8;
`ifdef UART_FRAME_CHECKSUM_EN
            r_csum   <= r_csum ^ r_shadow[8*NBYTES-1 -: 8];
`endif
          end
        end
        S_WAIT: begin
          if (tx_done_tick) begin
            if (r_idx == c_LAST_IDX) begin
              frame_done <= 1'b1;
              busy       <= 1'b0;
              r_state    <= S_IDLE;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= S_ISSUE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_frame_tx.sv
// ============================================================================
// Module   : tb_uart_frame_tx
// Purpose  : Self-checking bench for uart_frame_tx (NBYTES=4) with a
//            transmitter model and a byte scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_frame_tx;

  localparam int NB = 4;
`ifdef UART_FRAME_CHECKSUM_EN
  localparam int c_FLEN = NB + 2;
`else
  localparam int c_FLEN = NB + 1;
`endif

  logic            clk = 1'b0;
  logic            reset, send;
  logic [8*NB-1:0] payload;
  logic            tick_m, tick_f;
  wire             tx_done_tick = tick_m | tick_f;
  logic            tx_start, busy, frame_done;
  logic [7:0]      tx_data;

  uart_frame_tx #(.NBYTES(NB), .HEADER(8'hA5)) dut (
    .clk          (clk),
    .reset        (reset),
    .send         (send),
    .payload      (payload),
    .tx_done_tick (tx_done_tick),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  int         n_tests = 0, n_fail = 0;
  int         cyc = 0, last_trig = 0, cnt = 0;
  int         n_start = 0, n_done = 0, frames_expected = 0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transmitter model plus scoreboard consumer; everything sampled mid-cycle.
  always @(negedge clk) begin
    logic [7:0] e;
    tick_m = 1'b0;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        tick_m    = 1'b1;
        last_trig = cyc;
      end
    end
    if (tx_start) begin
      n_start++;
      if (exp_q.size() == 0) chk("unexpected_tx_start", {24'h0, tx_data}, 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        chk("tx_data", {24'h0, tx_data}, {24'h0, e});
      end
      chk("start_gap", cyc - last_trig, 2);
      cnt = 20;
    end
    if (frame_done) begin
      n_done++;
      chk("frame_done_expected", (frames_expected > 0) ? 1 : 0, 1);
      chk("frame_len", exp_q.size(), 0);
      chk("busy_at_done", {31'h0, busy}, 0);
      chk("done_gap", cyc - last_trig, 1);
      if (frames_expected > 0) frames_expected--;
    end
  end

  task automatic push_frame(input logic [31:0] p, input logic [7:0] cs);
    exp_q.push_back(8'hA5);
    for (int b = NB - 1; b >= 0; b--) exp_q.push_back(p[8*b +: 8]);
`ifdef UART_FRAME_CHECKSUM_EN
    exp_q.push_back(cs);
`else
    if (cs == 8'h00) begin end
`endif
    frames_expected++;
    last_trig = cyc;
  endtask

  task automatic do_send(input logic [31:0] p, input logic [7:0] cs);
    @(negedge clk);
    payload = p;
    send    = 1'b1;
    push_frame(p, cs);
    @(negedge clk);
    send = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int k = 0;
    while (n_done < target && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("frame_timeout", n_done, target);
  endtask

  task automatic wait_starts(input int target);
    int k = 0;
    while (n_start < target && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("start_timeout", n_start, target);
  endtask

  typedef struct {
    logic [31:0] payload;
    logic [7:0]  csum;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int   target, base, k;
    tbl[0] = '{32'h1122_3344, 8'h44};
    tbl[1] = '{32'h0F0F_00FF, 8'hFF};
    tbl[2] = '{32'h0000_0000, 8'h00};
    tbl[3] = '{32'hFFFF_FFFF, 8'h00};
    tbl[4] = '{32'hA5A5_A5A5, 8'h00};
    tbl[5] = '{32'h0102_0408, 8'h0F};

    reset = 1'b1; send = 1'b0; payload = '0; tick_f = 1'b0; tick_m = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_start", {31'h0, tx_start}, 0);
    chk("rst_tx_data", {24'h0, tx_data}, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_frame_done", {31'h0, frame_done}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven frames
    target = 0;
    foreach (tbl[i]) begin
      do_send(tbl[i].payload, tbl[i].csum);
      chk("busy_after_send", {31'h0, busy}, 1);
      target++;
      wait_frames(target);
      @(negedge clk);
      chk("busy_idle", {31'h0, busy}, 0);
      repeat (3) @(negedge clk);
    end

    // Payload change and send while busy
    base = n_start;
    do_send(32'hA1B2_C3D4, 8'h04);
    wait_starts(base + 3);
    repeat (5) @(negedge clk);
    payload = 32'hDEAD_BEEF;
    send    = 1'b1;
    chk("busy_during_frame", {31'h0, busy}, 1);
    @(negedge clk);
    send = 1'b0;
    chk("busy_still", {31'h0, busy}, 1);
    target++;
    wait_frames(target);
    repeat (40) @(negedge clk);
    chk("no_extra_frame", n_start - base, c_FLEN);

    // Back-to-back: send with frame_done ignored, send one cycle later accepted
    do_send(32'h1234_5678, 8'h08);
    k = 0;
    do begin @(negedge clk); k++; end while (!frame_done && k < 400);
    chk("fd_wait", {31'h0, frame_done}, 1);
    payload = 32'h5A5A_5A5A;
    send    = 1'b1;
    @(negedge clk);
    push_frame(32'h5A5A_5A5A, 8'h00);
    @(negedge clk);
    send = 1'b0;
    chk("b2b_busy", {31'h0, busy}, 1);
    target += 2;
    wait_frames(target);
    repeat (3) @(negedge clk);

    // Reset in WAIT after byte 1
    base = n_start;
    do_send(32'hCAFE_0001, 8'h35);
    wait_starts(base + 2);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    frames_expected = 0;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_tx_start", {31'h0, tx_start}, 0);
    chk("abort_tx_data", {24'h0, tx_data}, 0);
    chk("abort_busy", {31'h0, busy}, 0);
    chk("abort_frame_done", {31'h0, frame_done}, 0);
    repeat (40) @(negedge clk);
    chk("abort_no_start", n_start - base, 2);
    chk("abort_no_done", n_done, target);
    do_send(32'h00FF_00FF, 8'h00);
    target++;
    wait_frames(target);
    repeat (3) @(negedge clk);

    // Spurious ticks in IDLE and in the ISSUE cycle
    base = n_start;
    tick_f = 1'b1;
    @(negedge clk);
    tick_f = 1'b0;
    repeat (5) @(negedge clk);
    chk("spur_idle_start", n_start - base, 0);
    chk("spur_idle_done", n_done, target);
    chk("spur_idle_busy", {31'h0, busy}, 0);
    do_send(32'h8040_2010, 8'hF0);
    tick_f = 1'b1;
    @(negedge clk);
    tick_f = 1'b0;
    target++;
    wait_frames(target);
    repeat (5) @(negedge clk);
    chk("spur_issue_starts", n_start - base, c_FLEN);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
